vga_cursor_overlay: RTL and testbench

//  - Pixel-domain stage directly downstream of the VGA frame-buffer controller.
//  - Consumes its BLANK_n/HS/VS/RGB stream and overlays a 16x16 2-bit hardware cursor sprite.
//  - Emits a re-timed stream to the DAC pins.
//  - Tracks active-area x/y itself by counting BLANK_n; needs no sync-generator counters.

---
 rtl/vga_overlay_pkg.sv | 22 ++
 rtl/cursor_bitmap_ram.sv | 24 ++
 rtl/vga_cursor_overlay.sv | 152 +++++++++++++++
 tb/tb_vga_cursor_overlay.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_overlay_pkg.sv
// Shared constants and types for the VGA cursor overlay stage.
package vga_overlay_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int POS_W    = 10;

    localparam int COLOR_W  = 8;
    localparam int RGB_W    = 3 * COLOR_W;

    localparam logic [1:0] CUR_TRANSP = 2'd0;
    localparam logic [1:0] CUR_COL0   = 2'd1;
    localparam logic [1:0] CUR_COL1   = 2'd2;
    localparam logic [1:0] CUR_INV    = 2'd3;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/cursor_bitmap_ram.sv
// Cursor sprite store: simple dual-port, single clock, registered read.
// A read that collides with a write to the same address returns the old code.
module cursor_bitmap_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_cursor_overlay.sv
// Overlays a 16x16 2-bit hardware cursor on the frame-buffer pixel stream.
// Position is tracked from BLANK_n; output is the input re-timed by two clocks.
module vga_cursor_overlay
    import vga_overlay_pkg::rgb_t, vga_overlay_pkg::POS_W, vga_overlay_pkg::COLOR_W,
           vga_overlay_pkg::RGB_W;
#(
    parameter int H_ACTIVE = vga_overlay_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_overlay_pkg::V_ACTIVE,
    parameter int CUR_LOG2 = 4
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST_n,
    input  logic                  iBLANK_n,
    input  logic                  iHS,
    input  logic                  iVS,
    input  logic [COLOR_W-1:0]    iR,
    input  logic [COLOR_W-1:0]    iG,
    input  logic [COLOR_W-1:0]    iB,
    input  logic                  icur_en,
    input  logic [POS_W-1:0]      icur_x,
    input  logic [POS_W-1:0]      icur_y,
    input  logic [RGB_W-1:0]      icol0,
    input  logic [RGB_W-1:0]      icol1,
    input  logic                  ibm_wren,
    input  logic [2*CUR_LOG2-1:0] ibm_addr,
    input  logic [1:0]            ibm_data,
    output logic                  oBLANK_n,
    output logic                  oHS,
    output logic                  oVS,
    output logic [COLOR_W-1:0]    oR,
    output logic [COLOR_W-1:0]    oG,
    output logic [COLOR_W-1:0]    oB
);

    localparam int               AW       = 2 * CUR_LOG2;
    localparam logic [POS_W-1:0] H_LIM    = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_LIM    = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_ACTIVE - 1);
    localparam logic [POS_W-1:0] CUR_EDGE = POS_W'(1 << CUR_LOG2);

    function automatic rgb_t mix_pixel(input logic hit, input logic [1:0] code,
                                       input rgb_t pix, input rgb_t c0, input rgb_t c1);
        rgb_t res;
        res = pix;
        if (hit) begin
            case (code)
                vga_overlay_pkg::CUR_COL0: res = c0;
                vga_overlay_pkg::CUR_COL1: res = c1;
                vga_overlay_pkg::CUR_INV:  res = rgb_t'(~pix);
                default:                   res = pix;
            endcase
        end
        return res;
    endfunction

    logic [POS_W-1:0] x, y, sx, sy;
    logic             blank_d, en_s, frame_ok;

    // Position counters and frame-start shadows; cursor stays off until a VS is seen.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x        <= '0;
            y        <= '0;
            blank_d  <= 1'b0;
            en_s     <= 1'b0;
            sx       <= '0;
            sy       <= '0;
            frame_ok <= 1'b0;
        end else begin
            blank_d <= iBLANK_n;
            if (iBLANK_n) begin
                x <= x + POS_W'(1);
            end else begin
                x <= '0;
            end
            if (!iVS) begin
                y        <= '0;
                frame_ok <= 1'b1;
                en_s     <= icur_en;
                sx       <= icur_x;
                sy       <= icur_y;
            end else if (blank_d && !iBLANK_n && y != V_LAST) begin
                y <= y + POS_W'(1);
            end
        end
    end

    logic [POS_W-1:0] dx, dy;
    logic             on_screen, hit_p0;
    logic [AW-1:0]    rd_addr;

    always_comb begin
        dx        = x - sx;
        dy        = y - sy;
        on_screen = (sx < H_LIM) && (sy < V_LIM);
        hit_p0    = en_s && frame_ok && iBLANK_n && on_screen &&
                    (x >= sx) && (y >= sy) && (dx < CUR_EDGE) && (dy < CUR_EDGE);
        rd_addr   = {dy[CUR_LOG2-1:0], dx[CUR_LOG2-1:0]};
    end

    logic [1:0] code_p1;

    cursor_bitmap_ram #(
        .ADDR_W (AW),
        .DATA_W (2)
    ) u_bitmap (
        .clk     (iVGA_CLK),
        .wr_en   (ibm_wren),
        .wr_addr (ibm_addr),
        .wr_data (ibm_data),
        .rd_addr (rd_addr),
        .rd_data (code_p1)
    );

    // Stage 1: register sync, hit flag and pixel alongside the bitmap read.
    logic blank_p1, hs_p1, vs_p1, hit_p1;
    rgb_t pix_p1;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            blank_p1 <= 1'b0;
            hs_p1    <= 1'b1;
            vs_p1    <= 1'b1;
            hit_p1   <= 1'b0;
        end else begin
            blank_p1 <= iBLANK_n;
            hs_p1    <= iHS;
            vs_p1    <= iVS;
            hit_p1   <= hit_p0;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        pix_p1 <= rgb_t'({iR, iG, iB});
    end

    // Stage 2: mix cursor code into the pixel and drive the DAC pins.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oBLANK_n     <= 1'b0;
            oHS          <= 1'b1;
            oVS          <= 1'b1;
            {oR, oG, oB} <= '0;
        end else begin
            oBLANK_n     <= blank_p1;
            oHS          <= hs_p1;
            oVS          <= vs_p1;
            {oR, oG, oB} <= mix_pixel(hit_p1, code_p1, pix_p1, rgb_t'(icol0), rgb_t'(icol1));
        end
    end

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Bench for vga_cursor_overlay: scoreboard over every output cycle plus a
// table of single-pixel probes and hand-written frame sequences.
module tb_vga_cursor_overlay;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       blank_n = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [7:0] r = '0, g = '0, b = '0;
    logic       cur_en = 1'b0;
    logic [9:0] cur_x = '0, cur_y = '0;
    logic [23:0] col0 = 24'hFF0000, col1 = 24'h00FF00;
    logic       bm_wren = 1'b0;
    logic [7:0] bm_addr = '0;
    logic [1:0] bm_data = '0;
    logic       o_blank_n, o_hs, o_vs;
    logic [7:0] o_r, o_g, o_b;

    always #5 clk = ~clk;

    vga_cursor_overlay dut (
        .iVGA_CLK (clk),     .iRST_n  (rst_n),
        .iBLANK_n (blank_n), .iHS     (hs),      .iVS     (vs),
        .iR       (r),       .iG      (g),       .iB      (b),
        .icur_en  (cur_en),  .icur_x  (cur_x),   .icur_y  (cur_y),
        .icol0    (col0),    .icol1   (col1),
        .ibm_wren (bm_wren), .ibm_addr(bm_addr), .ibm_data(bm_data),
        .oBLANK_n (o_blank_n), .oHS   (o_hs),    .oVS     (o_vs),
        .oR       (o_r),     .oG      (o_g),     .oB      (o_b)
    );

    typedef struct {
        logic        blank_n, hs, vs;
        logic [23:0] rgb;
        bit          probe;
    } exp_t;

    typedef struct {
        string       name;
        bit          en;
        int          cx, cy;
        logic [7:0]  addr;
        logic [1:0]  code;
        int          prow, pcol;
        logic [23:0] in_rgb, want;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   checks = 0, errors = 0;

    logic [1:0] bm_m [256];
    bit         m_ok = 0, m_en = 0;
    int         m_x = 0, m_y = 0;

    bit          use_fixed = 0, coll_arm = 0;
    logic [23:0] fixed_rgb = '0, probe_in = '0, probe_rgb = '0;
    logic [23:0] cnt_target = 24'hFF0000;
    int          probe_row = -1, probe_col = -1, hit_cnt = 0;

    function automatic logic [23:0] pix(input int row, input int col);
        if (row == probe_row && col == probe_col) return probe_in;
        if (use_fixed) return fixed_rgb;
        return {8'(row), 8'(col), 8'h5A};
    endfunction

    function automatic logic [23:0] model_pix(input int row, input int col, input logic bl,
                                              input logic [23:0] rgb);
        int dx, dy;
        logic [1:0] c;
        dx = col - m_x;
        dy = row - m_y;
        if (!bl || !m_ok || !m_en || m_x >= 640 || m_y >= 480) return rgb;
        if (dx < 0 || dy < 0 || dx > 15 || dy > 15) return rgb;
        c = bm_m[dy * 16 + dx];
        case (c)
            2'd1:    return col0;
            2'd2:    return col1;
            2'd3:    return ~rgb;
            default: return rgb;
        endcase
    endfunction

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic check_rgb(input string nm, input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %06h, want %06h", nm, got, want);
        end
    endtask

    task automatic check_out(input exp_t e);
        logic [23:0] act;
        act = {o_r, o_g, o_b};
        checks++;
        if (o_blank_n !== e.blank_n || o_hs !== e.hs || o_vs !== e.vs || act !== e.rgb) begin
            errors++;
            $display("FAIL pipe_out @%0t: got blank=%b hs=%b vs=%b rgb=%06h, want blank=%b hs=%b vs=%b rgb=%06h",
                     $time, o_blank_n, o_hs, o_vs, act, e.blank_n, e.hs, e.vs, e.rgb);
        end
        if (e.probe) probe_rgb = act;
        if (o_blank_n && act == cnt_target) hit_cnt++;
    endtask

    // One pixel clock: drive, predict, advance, compare the entry now leaving the pipe.
    task automatic step(input int row, input int col, input logic bl, input logic h, input logic v);
        exp_t e;
        logic [23:0] rgb;
        bit is_probe;
        is_probe = bl && row == probe_row && col == probe_col;
        rgb = bl ? pix(row, col) : 24'h0A0B0C;
        if (is_probe && coll_arm) begin
            bm_wren = 1'b1; bm_addr = 8'h00; bm_data = 2'd2; coll_arm = 0;
        end
        blank_n = bl; hs = h; vs = v; {r, g, b} = rgb;
        e.blank_n = bl; e.hs = h; e.vs = v; e.probe = is_probe;
        e.rgb = model_pix(row, col, bl, rgb);
        exp_q.push_back(e);
        if (bm_wren) bm_m[bm_addr] = bm_data;
        if (!v) begin
            m_ok = 1; m_en = cur_en; m_x = int'(cur_x); m_y = int'(cur_y);
        end
        @(posedge clk);
        #1;
        bm_wren = 1'b0;
        if (exp_q.size() >= 2) check_out(exp_q.pop_front());
    endtask

    task automatic vsync();
        step(0, 0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1, 1);
    endtask

    task automatic line(input int row, input int start, input int width);
        for (int c = start; c < width; c++) step(row, c, 1, 1, 1);
        step(row, width, 0, 1, 1);
        step(row, width, 0, 0, 1);
        step(row, width, 0, 1, 1);
    endtask

    task automatic frame(input int n, input int wide_from, input int width);
        vsync();
        for (int row = 0; row < n; row++) line(row, 0, (row < wide_from) ? 1 : width);
    endtask

    task automatic bm_write(input logic [7:0] a, input logic [1:0] d);
        bm_wren = 1'b1; bm_addr = a; bm_data = d;
        step(0, 0, 0, 1, 1);
    endtask

    task automatic bm_fill(input logic [1:0] d);
        for (int i = 0; i < 256; i++) bm_write(8'(i), d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; blank_n = 1'b0; hs = 1'b1; vs = 1'b1; bm_wren = 1'b0;
        #2;
        checks++;
        if ({o_r, o_g, o_b} !== 24'h0 || o_blank_n !== 1'b0 || o_hs !== 1'b1 || o_vs !== 1'b1) begin
            errors++;
            $display("FAIL reset_out: got blank=%b hs=%b vs=%b rgb=%06h, want blank=0 hs=1 vs=1 rgb=000000",
                     o_blank_n, o_hs, o_vs, {o_r, o_g, o_b});
        end
        exp_q.delete();
        m_ok = 0; m_en = 0; m_x = 0; m_y = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic add_vec(input string nm, input bit en, input int cx, input int cy,
                           input logic [7:0] a, input logic [1:0] c, input int pr, input int pc,
                           input logic [23:0] in_rgb, input logic [23:0] want);
        vec_t v;
        v.name = nm; v.en = en; v.cx = cx; v.cy = cy; v.addr = a; v.code = c;
        v.prow = pr; v.pcol = pc; v.in_rgb = in_rgb; v.want = want;
        tbl.push_back(v);
    endtask

    initial begin
        add_vec("code1",      1,  10,  5, 8'h00, 2'd1,  5,  10, 24'h0F0F0F, 24'hFF0000);
        add_vec("code2",      1,  10,  5, 8'h00, 2'd2,  5,  10, 24'h0F0F0F, 24'h00FF00);
        add_vec("code3",      1,  10,  5, 8'h00, 2'd3,  5,  10, 24'h0F0F0F, 24'hF0F0F0);
        add_vec("code0",      1,  10,  5, 8'h00, 2'd0,  5,  10, 24'h0F0F0F, 24'h0F0F0F);
        add_vec("disabled",   0,  10,  5, 8'h00, 2'd1,  5,  10, 24'h0F0F0F, 24'h0F0F0F);
        add_vec("corner15",   1,  10,  5, 8'hFF, 2'd1, 20,  25, 24'h0F0F0F, 24'hFF0000);
        add_vec("dx16",       1,  10,  5, 8'h00, 2'd1,  5,  26, 24'h0F0F0F, 24'h0F0F0F);
        add_vec("dy16",       1,  10,  5, 8'h00, 2'd1, 21,  10, 24'h0F0F0F, 24'h0F0F0F);
        add_vec("left_of",    1,  10,  5, 8'h0F, 2'd1,  5,   9, 24'h0F0F0F, 24'h0F0F0F);
        add_vec("above",      1,  10,  5, 8'hF0, 2'd1,  4,  10, 24'h0F0F0F, 24'h0F0F0F);
        add_vec("inv_origin", 1,   0,  0, 8'h00, 2'd3,  0,   0, 24'hFFFFFF, 24'h000000);
        add_vec("inv_spec",   1, 100, 50, 8'h00, 2'd3, 50, 100, 24'h0F0F0F, 24'hF0F0F0);

        @(posedge clk);
        #1;
        do_reset();

        // Plain pass-through with the cursor disabled.
        cur_en = 0; use_fixed = 1; fixed_rgb = 24'h123456;
        frame(4, 0, 20);
        use_fixed = 0;

        // Solid 16x16 block of col0 at (100,50).
        bm_fill(2'd1);
        cur_en = 1; cur_x = 10'd100; cur_y = 10'd50;
        hit_cnt = 0;
        frame(70, 0, 120);
        check_int("t2_block_pixels", hit_cnt, 256);

        // Single-pixel probes.
        bm_fill(2'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            cur_en = tbl[i].en; cur_x = 10'(tbl[i].cx); cur_y = 10'(tbl[i].cy);
            bm_write(tbl[i].addr, tbl[i].code);
            probe_row = tbl[i].prow; probe_col = tbl[i].pcol;
            probe_in = tbl[i].in_rgb; probe_rgb = 24'hDEAD01;
            frame(tbl[i].prow + 2, tbl[i].prow, tbl[i].pcol + 3);
            check_rgb({"vec_", tbl[i].name}, probe_rgb, tbl[i].want);
        end
        probe_row = -1; probe_col = -1;

        // Bottom-right clipping, then a cursor entirely off screen.
        bm_fill(2'd1);
        cur_en = 1; cur_x = 10'd630; cur_y = 10'd470;
        hit_cnt = 0;
        frame(480, 465, 640);
        check_int("t4_corner_pixels", hit_cnt, 100);
        cur_x = 10'd700; cur_y = 10'd10;
        hit_cnt = 0;
        frame(20, 0, 640);
        check_int("t4_offscreen_pixels", hit_cnt, 0);

        // Mid-frame position change only takes effect at the next VS.
        cur_x = 10'd100; cur_y = 10'd50;
        hit_cnt = 0;
        vsync();
        for (int row = 0; row < 70; row++) begin
            if (row == 10) cur_x = 10'd20;
            line(row, 0, 120);
        end
        check_int("t5_no_tearing", hit_cnt, 256);
        hit_cnt = 0;
        frame(70, 0, 120);
        check_int("t5_next_frame", hit_cnt, 256);

        // Reset mid-line: pass-through until the next VS.
        cur_x = 10'd100;
        vsync();
        for (int row = 0; row < 50; row++) line(row, 0, 1);
        for (int c = 0; c < 105; c++) step(50, c, 1, 1, 1);
        do_reset();
        hit_cnt = 0;
        line(50, 105, 120);
        for (int row = 51; row < 66; row++) line(row, 0, 120);
        check_int("t5_reset_passthru", hit_cnt, 0);
        hit_cnt = 0;
        frame(70, 0, 120);
        check_int("t5_recover", hit_cnt, 256);

        // Write/read collision on address 0.
        bm_fill(2'd0);
        bm_write(8'h00, 2'd1);
        cur_en = 1; cur_x = 10'd10; cur_y = 10'd5;
        probe_row = 5; probe_col = 10; probe_in = 24'h0F0F0F;
        coll_arm = 1; probe_rgb = 24'hDEAD02;
        frame(7, 5, 13);
        check_rgb("t6_collision_old", probe_rgb, 24'hFF0000);
        probe_rgb = 24'hDEAD03;
        frame(7, 5, 13);
        check_rgb("t6_collision_new", probe_rgb, 24'h00FF00);

        repeat (2) step(0, 0, 0, 1, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
